ks_control_unit_mw: RTL and testbench

//  Multicycle K&S control FSM, next generation. Adds a memory-ready handshake with a wait-state

---
 rtl/k_and_s_pkg.sv | 36 +++
 rtl/ks_mem_wait_timer.sv | 42 ++++
 rtl/ks_control_unit_mw.sv | 197 +++++++++++++++++++
 tb/tb_ks_control_unit_mw.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S control path: decoded instruction
// encoding, ALU operation codes and a timer width helper.
package k_and_s_pkg;

  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_HALT   = 5'd13,
    I_BOV    = 5'd14,
    I_BUOV   = 5'd15
  } decoded_instruction_type;

  // ALU codes kept as plain integers so any OP_W >= 3 can carry them.
  localparam int ALU_PASS = 0;
  localparam int ALU_ADD  = 1;
  localparam int ALU_SUB  = 2;
  localparam int ALU_AND  = 3;
  localparam int ALU_OR   = 4;

  // Timer needs to hold 0..MEM_TIMEOUT; keep at least one bit when disabled.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/ks_mem_wait_timer.sv
// Wait-state timer: cleared outside memory waits, counts cycles without
// mem_ready, flags expiry on the cycle the MEM_TIMEOUT-th stall would occur.
module ks_mem_wait_timer
  import k_and_s_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int TW = timer_width(MEM_TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [TW-1:0] timer_q, timer_d;

  // Next timer value: clear wins over count.
  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (count_i) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Timer register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // A zero timeout disables expiry entirely.
  assign expire_o = (MEM_TIMEOUT != 0) && count_i && (timer_q == LAST);

endmodule

// File: rtl/ks_control_unit_mw.sv
// Multicycle K&S control FSM with memory-ready handshake, wait-state timeout
// fault, overflow branches and a retired-instruction counter.
//
// state    | meaning
// ---------+--------------------------------------------------
// RST_S    | post-reset idle, all controls low
// FETCH    | read instruction, wait for mem_ready
// IR_LD    | load instruction register
// DECODE   | sample instruction and flags, latch ALU op
// EXEC     | ALU operation, update flags (not for MOVE)
// WB       | write ALU result to register file
// MEM_ADDR | drive data address for LOAD/STORE
// LD_WAIT  | data read, wait for mem_ready
// WB_LOAD  | write loaded data to register file
// ST_WAIT  | data write, wait for mem_ready
// BR       | take branch, update PC
// PC_EN    | sequential PC increment
// HALTED   | stopped by HALT until reset
// FAULT    | memory timeout, stopped until reset
module ks_control_unit_mw
  import k_and_s_pkg::*;
#(
  parameter int OP_W        = 3,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter bit HAS_OVF_BR  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  decoded_instruction_type decoded_instruction_i,
  input  logic                    zero_op_i,
  input  logic                    neg_op_i,
  input  logic                    unsigned_overflow_i,
  input  logic                    signed_overflow_i,
  input  logic                    mem_ready_i,
  output logic                    branch_o,
  output logic                    pc_enable_o,
  output logic                    ir_enable_o,
  output logic                    write_reg_enable_o,
  output logic                    addr_sel_o,
  output logic                    c_sel_o,
  output logic                    flags_reg_enable_o,
  output logic [OP_W-1:0]         operation_o,
  output logic                    ram_read_enable_o,
  output logic                    ram_write_enable_o,
  output logic                    halt_o,
  output logic                    mem_fault_o,
  output logic [CNT_W-1:0]        retired_cnt_o
);

  if (OP_W < 3) begin : g_op_w_check
    $error("ks_control_unit_mw: OP_W must be >= 3");
  end

  typedef enum logic [3:0] {
    RST_S, FETCH, IR_LD, DECODE, EXEC, WB, MEM_ADDR,
    LD_WAIT, WB_LOAD, ST_WAIT, BR, PC_EN, HALTED, FAULT
  } state_t;

  state_t                  state_q, state_d;
  decoded_instruction_type instr_q, instr_d;
  logic [OP_W-1:0]         operation_q, operation_d;
  logic [CNT_W-1:0]        retired_q;
  logic                    in_wait, tmr_expire, retire;

  assign in_wait = (state_q == FETCH) || (state_q == LD_WAIT) || (state_q == ST_WAIT);
  assign retire  = (state_q == BR) || (state_q == PC_EN);

  ks_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (!in_wait),
    .count_i  (in_wait && !mem_ready_i),
    .expire_o (tmr_expire)
  );

  // Next-state decode and Moore control outputs.
  always_comb begin
    state_d            = state_q;
    instr_d            = instr_q;
    operation_d        = operation_q;
    branch_o           = 1'b0;
    pc_enable_o        = 1'b0;
    ir_enable_o        = 1'b0;
    write_reg_enable_o = 1'b0;
    addr_sel_o         = 1'b0;
    c_sel_o            = 1'b0;
    flags_reg_enable_o = 1'b0;
    ram_read_enable_o  = 1'b0;
    ram_write_enable_o = 1'b0;
    halt_o             = 1'b0;
    mem_fault_o        = 1'b0;
    case (state_q)
      RST_S: state_d = FETCH;
      FETCH: begin
        addr_sel_o        = 1'b1;
        ram_read_enable_o = 1'b1;
        if (mem_ready_i)     state_d = IR_LD;
        else if (tmr_expire) state_d = FAULT;
      end
      IR_LD: begin
        addr_sel_o  = 1'b1;
        ir_enable_o = 1'b1;
        state_d     = DECODE;
      end
      DECODE: begin
        instr_d = decoded_instruction_i;
        case (decoded_instruction_i)
          I_MOVE:   begin operation_d = OP_W'(ALU_PASS); state_d = EXEC; end
          I_ADD:    begin operation_d = OP_W'(ALU_ADD);  state_d = EXEC; end
          I_SUB:    begin operation_d = OP_W'(ALU_SUB);  state_d = EXEC; end
          I_AND:    begin operation_d = OP_W'(ALU_AND);  state_d = EXEC; end
          I_OR:     begin operation_d = OP_W'(ALU_OR);   state_d = EXEC; end
          I_LOAD,
          I_STORE:  state_d = MEM_ADDR;
          I_BRANCH: state_d = BR;
          I_BZERO:  state_d = zero_op_i  ? BR : PC_EN;
          I_BNZERO: state_d = !zero_op_i ? BR : PC_EN;
          I_BNEG:   state_d = neg_op_i   ? BR : PC_EN;
          I_BNNEG:  state_d = !neg_op_i  ? BR : PC_EN;
          I_BOV:    state_d = (HAS_OVF_BR && signed_overflow_i)   ? BR : PC_EN;
          I_BUOV:   state_d = (HAS_OVF_BR && unsigned_overflow_i) ? BR : PC_EN;
          I_HALT:   state_d = HALTED;
          default:  state_d = PC_EN;
        endcase
      end
      EXEC: begin
        flags_reg_enable_o = (instr_q != I_MOVE);
        state_d            = WB;
      end
      WB: begin
        write_reg_enable_o = 1'b1;
        state_d            = PC_EN;
      end
      MEM_ADDR: state_d = (instr_q == I_STORE) ? ST_WAIT : LD_WAIT;
      LD_WAIT: begin
        ram_read_enable_o = 1'b1;
        if (mem_ready_i)     state_d = WB_LOAD;
        else if (tmr_expire) state_d = FAULT;
      end
      WB_LOAD: begin
        c_sel_o            = 1'b1;
        write_reg_enable_o = 1'b1;
        state_d            = PC_EN;
      end
      ST_WAIT: begin
        ram_write_enable_o = 1'b1;
        if (mem_ready_i)     state_d = PC_EN;
        else if (tmr_expire) state_d = FAULT;
      end
      BR: begin
        branch_o    = 1'b1;
        pc_enable_o = 1'b1;
        state_d     = FETCH;
      end
      PC_EN: begin
        pc_enable_o = 1'b1;
        addr_sel_o  = 1'b1;
        state_d     = FETCH;
      end
      HALTED: halt_o = 1'b1;
      FAULT: begin
        halt_o      = 1'b1;
        mem_fault_o = 1'b1;
      end
      default: state_d = RST_S;
    endcase
  end

  // State, latched instruction and ALU op registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RST_S;
      instr_q     <= I_NOP;
      operation_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      operation_q <= operation_d;
    end
  end

  // Retired-instruction counter, bumped as BR or PC_EN hands back to FETCH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign operation_o   = operation_q;
  assign retired_cnt_o = retired_q;

endmodule

// File: tb/tb_ks_control_unit_mw.sv
module tb_ks_control_unit_mw;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  decoded_instruction_type instr;
  logic zero_op, neg_op, uovf, sovf, mem_ready;

  // {branch, pc_en, ir_en, wr_en, addr_sel, c_sel, flags_en, rd, wr, halt, fault}
  wire [10:0] ctl_a, ctl_b, ctl_c;
  wire [2:0]  op_a, op_b, op_c;
  wire [15:0] ret_a, ret_b;
  wire [3:0]  ret_c;

  localparam logic [10:0] C_BR = 11'h400, C_PC = 11'h200, C_IR = 11'h100, C_WR = 11'h080;
  localparam logic [10:0] C_AS = 11'h040, C_CS = 11'h020, C_FE = 11'h010, C_RR = 11'h008;
  localparam logic [10:0] C_RW = 11'h004, C_HL = 11'h002, C_MF = 11'h001;
  localparam logic [10:0] S_FETCH = C_AS | C_RR, S_IRLD = C_AS | C_IR, S_DEC = 11'h000;
  localparam logic [10:0] S_EXEC = C_FE, S_WB = C_WR, S_MADR = 11'h000, S_LDW = C_RR;
  localparam logic [10:0] S_WBL = C_CS | C_WR, S_STW = C_RW, S_BRS = C_BR | C_PC;
  localparam logic [10:0] S_PCEN = C_PC | C_AS, S_HALT = C_HL, S_FAULT = C_HL | C_MF;

  ks_control_unit_mw #(.OP_W(3), .CNT_W(16), .MEM_TIMEOUT(4), .HAS_OVF_BR(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .decoded_instruction_i(instr),
    .zero_op_i(zero_op), .neg_op_i(neg_op), .unsigned_overflow_i(uovf),
    .signed_overflow_i(sovf), .mem_ready_i(mem_ready),
    .branch_o(ctl_a[10]), .pc_enable_o(ctl_a[9]), .ir_enable_o(ctl_a[8]),
    .write_reg_enable_o(ctl_a[7]), .addr_sel_o(ctl_a[6]), .c_sel_o(ctl_a[5]),
    .flags_reg_enable_o(ctl_a[4]), .operation_o(op_a), .ram_read_enable_o(ctl_a[3]),
    .ram_write_enable_o(ctl_a[2]), .halt_o(ctl_a[1]), .mem_fault_o(ctl_a[0]),
    .retired_cnt_o(ret_a));

  ks_control_unit_mw #(.OP_W(3), .CNT_W(16), .MEM_TIMEOUT(4), .HAS_OVF_BR(1'b0)) u_novf (
    .clk_i(clk), .rst_i(rst), .decoded_instruction_i(instr),
    .zero_op_i(zero_op), .neg_op_i(neg_op), .unsigned_overflow_i(uovf),
    .signed_overflow_i(sovf), .mem_ready_i(mem_ready),
    .branch_o(ctl_b[10]), .pc_enable_o(ctl_b[9]), .ir_enable_o(ctl_b[8]),
    .write_reg_enable_o(ctl_b[7]), .addr_sel_o(ctl_b[6]), .c_sel_o(ctl_b[5]),
    .flags_reg_enable_o(ctl_b[4]), .operation_o(op_b), .ram_read_enable_o(ctl_b[3]),
    .ram_write_enable_o(ctl_b[2]), .halt_o(ctl_b[1]), .mem_fault_o(ctl_b[0]),
    .retired_cnt_o(ret_b));

  ks_control_unit_mw #(.OP_W(3), .CNT_W(4), .MEM_TIMEOUT(4), .HAS_OVF_BR(1'b1)) u_cnt4 (
    .clk_i(clk), .rst_i(rst), .decoded_instruction_i(instr),
    .zero_op_i(zero_op), .neg_op_i(neg_op), .unsigned_overflow_i(uovf),
    .signed_overflow_i(sovf), .mem_ready_i(mem_ready),
    .branch_o(ctl_c[10]), .pc_enable_o(ctl_c[9]), .ir_enable_o(ctl_c[8]),
    .write_reg_enable_o(ctl_c[7]), .addr_sel_o(ctl_c[6]), .c_sel_o(ctl_c[5]),
    .flags_reg_enable_o(ctl_c[4]), .operation_o(op_c), .ram_read_enable_o(ctl_c[3]),
    .ram_write_enable_o(ctl_c[2]), .halt_o(ctl_c[1]), .mem_fault_o(ctl_c[0]),
    .retired_cnt_o(ret_c));

  int errors = 0;
  int checks = 0;
  int exp_ret = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = I_NOP; mem_ready = 1'b1;
    zero_op = 1'b0; neg_op = 1'b0; uovf = 1'b0; sovf = 1'b0;
    tick(); tick();
    checks++; if (ctl_a !== 11'h000) begin errors++; $display("FAIL reset_ctl got=%h exp=%h", ctl_a, 11'h000); end
    checks++; if (op_a !== 3'd0) begin errors++; $display("FAIL reset_op got=%0d exp=0", op_a); end
    checks++; if (ret_a !== 16'd0) begin errors++; $display("FAIL reset_ret got=%0d exp=0", ret_a); end
    rst = 1'b0;
    tick();
    exp_ret = 0;
    checks++; if (ctl_a !== S_FETCH) begin errors++; $display("FAIL reset_fetch got=%h exp=%h", ctl_a, S_FETCH); end
    checks++; if (ret_a !== 16'd0) begin errors++; $display("FAIL reset_fetch_ret got=%0d exp=0", ret_a); end
  endtask

  task automatic test_alu(input decoded_instruction_type ins, input logic [2:0] exp_op,
                          input logic [10:0] exp_exec);
    logic [10:0] seq [6];
    seq = '{S_IRLD, S_DEC, exp_exec, S_WB, S_PCEN, S_FETCH};
    instr = ins;
    mem_ready = 1'b0;
    tick();
    checks++; if (ctl_a !== S_FETCH) begin errors++; $display("FAIL fetch_wait got=%h exp=%h", ctl_a, S_FETCH); end
    tick();
    checks++; if (ctl_a !== S_FETCH) begin errors++; $display("FAIL fetch_wait2 got=%h exp=%h", ctl_a, S_FETCH); end
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (ctl_a !== seq[i]) begin errors++; $display("FAIL alu_seq[%0d] got=%h exp=%h", i, ctl_a, seq[i]); end
      if (i == 2) begin
        checks++; if (op_a !== exp_op) begin errors++; $display("FAIL alu_op got=%0d exp=%0d", op_a, exp_op); end
      end
      if (i == 4) begin
        checks++; if (ret_a !== 16'(exp_ret)) begin errors++; $display("FAIL alu_ret_pre got=%0d exp=%0d", ret_a, exp_ret); end
      end
    end
    exp_ret++;
    checks++; if (ret_a !== 16'(exp_ret)) begin errors++; $display("FAIL alu_ret got=%0d exp=%0d", ret_a, exp_ret); end
  endtask

  task automatic test_load();
    logic [10:0] seq [3];
    int rd_cycles;
    seq = '{S_IRLD, S_DEC, S_MADR};
    rd_cycles = 0;
    instr = I_LOAD; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ctl_a !== seq[i]) begin errors++; $display("FAIL load_seq[%0d] got=%h exp=%h", i, ctl_a, seq[i]); end
    end
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ctl_a[3]) rd_cycles++;
      checks++; if (ctl_a !== S_LDW) begin errors++; $display("FAIL load_wait[%0d] got=%h exp=%h", k, ctl_a, S_LDW); end
      if (k == 3) mem_ready = 1'b1;
    end
    checks++; if (rd_cycles !== 4) begin errors++; $display("FAIL load_rd_cycles got=%0d exp=4", rd_cycles); end
    tick();
    checks++; if (ctl_a !== S_WBL) begin errors++; $display("FAIL load_wb got=%h exp=%h", ctl_a, S_WBL); end
    tick();
    checks++; if (ctl_a !== S_PCEN) begin errors++; $display("FAIL load_pcen got=%h exp=%h", ctl_a, S_PCEN); end
    tick();
    exp_ret++;
    checks++; if (ctl_a !== S_FETCH || ret_a !== 16'(exp_ret)) begin
      errors++; $display("FAIL load_end ctl=%h ret=%0d exp ctl=%h ret=%0d", ctl_a, ret_a, S_FETCH, exp_ret);
    end
  endtask

  task automatic test_store_ok();
    logic [10:0] seq [6];
    seq = '{S_IRLD, S_DEC, S_MADR, S_STW, S_PCEN, S_FETCH};
    instr = I_STORE; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (ctl_a !== seq[i]) begin errors++; $display("FAIL store_seq[%0d] got=%h exp=%h", i, ctl_a, seq[i]); end
    end
    exp_ret++;
    checks++; if (ret_a !== 16'(exp_ret)) begin errors++; $display("FAIL store_ret got=%0d exp=%0d", ret_a, exp_ret); end
  endtask

  task automatic test_branches();
    logic [4:0] codes [10];
    logic [3:0] flg   [10];
    logic       a_br  [10];
    logic       b_br  [10];
    logic [10:0] ea, eb;
    codes = '{5'd14, 5'd14, 5'd15, 5'd9, 5'd10, 5'd11, 5'd12, 5'd8, 5'd25, 5'd15};
    flg   = '{4'h1, 4'h0, 4'h2, 4'h8, 4'h8, 4'h4, 4'h4, 4'h0, 4'hF, 4'h1};
    a_br  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    b_br  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr = decoded_instruction_type'(codes[i]);
      {zero_op, neg_op, uovf, sovf} = flg[i];
      tick(); tick();
      checks++; if (ctl_a !== S_DEC) begin errors++; $display("FAIL br_dec[%0d] got=%h exp=%h", i, ctl_a, S_DEC); end
      tick();
      ea = a_br[i] ? S_BRS : S_PCEN;
      eb = b_br[i] ? S_BRS : S_PCEN;
      checks++; if (ctl_a !== ea) begin errors++; $display("FAIL br_take[%0d] got=%h exp=%h", i, ctl_a, ea); end
      checks++; if (ctl_b !== eb) begin errors++; $display("FAIL br_novf[%0d] got=%h exp=%h", i, ctl_b, eb); end
      tick();
      exp_ret++;
      checks++; if (ret_a !== 16'(exp_ret) || ret_b !== 16'(exp_ret)) begin
        errors++; $display("FAIL br_ret[%0d] got=%0d/%0d exp=%0d", i, ret_a, ret_b, exp_ret);
      end
    end
    {zero_op, neg_op, uovf, sovf} = 4'h0;
  endtask

  task automatic test_store_fault();
    instr = I_STORE; mem_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (ctl_a !== S_MADR) begin errors++; $display("FAIL flt_madr got=%h exp=%h", ctl_a, S_MADR); end
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (ctl_a !== S_STW) begin errors++; $display("FAIL flt_wait[%0d] got=%h exp=%h", k, ctl_a, S_STW); end
    end
    tick();
    checks++; if (ctl_a !== S_FAULT) begin errors++; $display("FAIL flt_fault got=%h exp=%h", ctl_a, S_FAULT); end
    checks++; if (ret_a !== 16'(exp_ret)) begin errors++; $display("FAIL flt_ret got=%0d exp=%0d", ret_a, exp_ret); end
    mem_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (ctl_a !== S_FAULT) begin errors++; $display("FAIL flt_hold got=%h exp=%h", ctl_a, S_FAULT); end
    rst = 1'b1;
    tick();
    checks++; if (ctl_a !== 11'h000 || ret_a !== 16'd0) begin
      errors++; $display("FAIL flt_rst ctl=%h ret=%0d exp ctl=000 ret=0", ctl_a, ret_a);
    end
    rst = 1'b0;
    exp_ret = 0;
    tick();
    checks++; if (ctl_a !== S_FETCH) begin errors++; $display("FAIL flt_fetch got=%h exp=%h", ctl_a, S_FETCH); end
  endtask

  task automatic test_wrap_halt();
    int halt_cycles;
    instr = I_NOP; mem_ready = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick(); tick(); tick();
      checks++; if (ctl_c !== S_PCEN) begin errors++; $display("FAIL nop_pcen[%0d] got=%h exp=%h", n, ctl_c, S_PCEN); end
      tick();
      exp_ret++;
      checks++; if (ret_c !== 4'(exp_ret % 16)) begin errors++; $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d", n, ret_c, exp_ret % 16); end
    end
    checks++; if (ret_a !== 16'd16) begin errors++; $display("FAIL wide_cnt got=%0d exp=16", ret_a); end
    instr = I_HALT;
    tick(); tick(); tick();
    checks++; if (ctl_c !== S_HALT) begin errors++; $display("FAIL halt_enter got=%h exp=%h", ctl_c, S_HALT); end
    instr = I_ADD;
    halt_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ctl_c === S_HALT && ctl_a === S_HALT) halt_cycles++;
    end
    checks++; if (halt_cycles !== 20) begin errors++; $display("FAIL halt_hold got=%0d exp=20", halt_cycles); end
    checks++; if (ret_c !== 4'd0 || ret_a !== 16'd16) begin
      errors++; $display("FAIL halt_frozen got=%0d/%0d exp=0/16", ret_c, ret_a);
    end
    rst = 1'b1;
    tick();
    checks++; if (ctl_a !== 11'h000) begin errors++; $display("FAIL halt_rst got=%h exp=000", ctl_a); end
    rst = 1'b0;
    tick();
    checks++; if (ctl_a !== S_FETCH) begin errors++; $display("FAIL halt_fetch got=%h exp=%h", ctl_a, S_FETCH); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu(I_ADD, 3'd1, S_EXEC);
    test_alu(I_MOVE, 3'd0, 11'h000);
    test_alu(I_OR, 3'd4, S_EXEC);
    test_load();
    test_store_ok();
    test_branches();
    test_store_fault();
    test_wrap_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
